// File: rtl/map_table_pkg.sv
// Types and sizing shared by the rename stage (free list, map table, ROB).
// The struct names are the shared interface names used by the rest of the pipeline.
package map_table_pkg;

    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned NUM_PR   = 64;
    localparam int unsigned NUM_CKPT = 4;
    localparam int unsigned ARW      = $clog2(NUM_ARCH);
    localparam int unsigned PRW      = $clog2(NUM_PR);
    localparam int unsigned CKW      = $clog2(NUM_CKPT);

    localparam logic [ARW-1:0] ZERO_REG = ARW'(31);
    localparam logic [PRW-1:0] ZERO_PR  = PRW'(31);

    typedef logic [ARW-1:0]           arch_idx_t;
    typedef logic [PRW-1:0]           tag_t;
    typedef logic [CKW-1:0]           ckpt_idx_t;
    typedef tag_t [NUM_ARCH-1:0]      map_arr_t;
    typedef logic [NUM_ARCH-1:0]      rdy_arr_t;

    typedef struct packed {
        arch_idx_t src1_idx;
        arch_idx_t src2_idx;
        arch_idx_t dest_idx;
    } DECODER_MAP_TABLE_OUT_t;

    typedef struct packed {
        tag_t T_idx;
    } FL_MAP_TABLE_OUT_t;

    typedef struct packed {
        logic valid;
        tag_t T_idx;
    } CDB_MAP_TABLE_OUT_t;

    typedef struct packed {
        tag_t T1_idx;
        logic T1_ready;
        tag_t T2_idx;
        logic T2_ready;
    } MAP_TABLE_RS_OUT_t;

    typedef struct packed {
        tag_t Told_idx;
    } MAP_TABLE_ROB_OUT_t;

    // One bit per architectural register whose mapping matches the broadcast tag.
    function automatic rdy_arr_t cdb_match(input map_arr_t m, input logic v, input tag_t t);
        rdy_arr_t hit;
        for (int i = 0; i < NUM_ARCH; i++) begin
            hit[i] = v && (m[i] == t);
        end
        return hit;
    endfunction

endpackage

// File: rtl/map_ckpt_bank.sv
// Branch checkpoint storage for the map table: snapshots, valid bits, tail
// pointer and the squash range used on a mispredict.
module map_ckpt_bank
    import map_table_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      take_en,
    input  map_arr_t  take_map,
    input  rdy_arr_t  take_rdy,
    input  logic      cdb_valid,
    input  tag_t      cdb_tag,
    input  logic      rollback_en,
    input  ckpt_idx_t rollback_ckpt,
    input  logic      resolve_en,
    input  ckpt_idx_t resolve_ckpt,
    output map_arr_t  restore_map,
    output rdy_arr_t  restore_rdy,
    output ckpt_idx_t ckpt_tail,
    output logic      ckpt_avail
);

    localparam int unsigned SPW = CKW + 1;

    map_arr_t              snap_map_q [NUM_CKPT];
    rdy_arr_t              snap_rdy_q [NUM_CKPT];
    logic [NUM_CKPT-1:0]   valid_q;
    logic [NUM_CKPT-1:0]   valid_d;
    logic [NUM_CKPT-1:0]   squash;
    ckpt_idx_t             tail_q;
    ckpt_idx_t             tail_d;
    ckpt_idx_t             offset;
    logic [SPW-1:0]        span;
    logic                  do_take;

    assign restore_map = snap_map_q[rollback_ckpt];
    assign restore_rdy = snap_rdy_q[rollback_ckpt];
    assign ckpt_tail   = tail_q;
    assign ckpt_avail  = !valid_q[tail_q];
    assign do_take     = take_en && !rollback_en && !valid_q[tail_q];

    // Squash range is [rollback_ckpt, tail) modulo NUM_CKPT; equal ends mean a full ring.
    always_comb begin
        offset  = '0;
        squash  = '0;
        span    = {1'b0, ckpt_idx_t'(tail_q - rollback_ckpt)};
        if (span == '0) begin
            span = SPW'(NUM_CKPT);
        end
        for (int k = 0; k < NUM_CKPT; k++) begin
            offset    = ckpt_idx_t'(k) - rollback_ckpt;
            squash[k] = rollback_en && ({1'b0, offset} < span);
        end

        valid_d = valid_q;
        if (resolve_en && !squash[resolve_ckpt]) begin
            valid_d[resolve_ckpt] = 1'b0;
        end
        valid_d = valid_d & ~squash;
        if (do_take) begin
            valid_d[tail_q] = 1'b1;
        end

        tail_d = tail_q;
        if (rollback_en) begin
            tail_d = rollback_ckpt;
        end else if (do_take) begin
            tail_d = tail_q + ckpt_idx_t'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            tail_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tail_q  <= tail_d;
        end
    end

    // Snapshot payload needs no reset: it is only read through a valid entry.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_CKPT; k++) begin
            if (do_take && (tail_q == ckpt_idx_t'(k))) begin
                snap_map_q[k] <= take_map;
                snap_rdy_q[k] <= take_rdy;
            end else begin
                snap_rdy_q[k] <= snap_rdy_q[k] | cdb_match(snap_map_q[k], cdb_valid, cdb_tag);
            end
        end
    end

endmodule

// File: rtl/map_table.sv
// Register-rename map table: source lookup with CDB bypass, Told return,
// destination install, CDB wakeup and single-cycle checkpoint restore.
module map_table
    import map_table_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            dispatch_en,
    input  logic [ARW-1:0]  src1_idx,
    input  logic [ARW-1:0]  src2_idx,
    input  logic [ARW-1:0]  dest_idx,
    input  logic [PRW-1:0]  T_idx,
    input  logic            ckpt_en,
    input  logic            CDB_valid,
    input  logic [PRW-1:0]  CDB_T_idx,
    input  logic            rollback_en,
    input  logic [CKW-1:0]  rollback_ckpt,
    input  logic            resolve_en,
    input  logic [CKW-1:0]  resolve_ckpt,
    output logic [PRW-1:0]  T1_idx,
    output logic [PRW-1:0]  T2_idx,
    output logic            T1_ready,
    output logic            T2_ready,
    output logic [PRW-1:0]  Told_idx,
    output logic [CKW-1:0]  ckpt_id,
    output logic            ckpt_avail
);

    DECODER_MAP_TABLE_OUT_t dec;
    FL_MAP_TABLE_OUT_t      fl;
    CDB_MAP_TABLE_OUT_t     cdb;
    MAP_TABLE_RS_OUT_t      rs;
    MAP_TABLE_ROB_OUT_t     rob;

    map_arr_t  map_q;
    map_arr_t  map_d;
    rdy_arr_t  rdy_q;
    rdy_arr_t  rdy_d;
    rdy_arr_t  cdb_live;
    map_arr_t  restore_map;
    rdy_arr_t  restore_rdy;
    ckpt_idx_t ckpt_tail;

    assign dec = '{src1_idx: src1_idx, src2_idx: src2_idx, dest_idx: dest_idx};
    assign fl  = '{T_idx: T_idx};
    assign cdb = '{valid: CDB_valid, T_idx: CDB_T_idx};

    assign cdb_live = cdb_match(map_q, cdb.valid, cdb.T_idx);

    // Lookups see the pre-edge table plus a same-cycle CDB bypass.
    always_comb begin
        rs.T1_idx    = map_q[dec.src1_idx];
        rs.T1_ready  = rdy_q[dec.src1_idx] | cdb_live[dec.src1_idx];
        rs.T2_idx    = map_q[dec.src2_idx];
        rs.T2_ready  = rdy_q[dec.src2_idx] | cdb_live[dec.src2_idx];
        rob.Told_idx = (dec.dest_idx == ZERO_REG) ? ZERO_PR : map_q[dec.dest_idx];
    end

    assign T1_idx   = rs.T1_idx;
    assign T1_ready = rs.T1_ready;
    assign T2_idx   = rs.T2_idx;
    assign T2_ready = rs.T2_ready;
    assign Told_idx = rob.Told_idx;
    assign ckpt_id  = ckpt_tail;

    // Rollback wins over dispatch; the rename's ready-clear wins over a CDB set.
    always_comb begin
        map_d = map_q;
        rdy_d = rdy_q | cdb_live;
        if (rollback_en) begin
            map_d = restore_map;
            rdy_d = restore_rdy | cdb_match(restore_map, cdb.valid, cdb.T_idx);
        end else if (dispatch_en && (dec.dest_idx != ZERO_REG)) begin
            map_d[dec.dest_idx] = fl.T_idx;
            rdy_d[dec.dest_idx] = 1'b0;
        end
        map_d[ZERO_REG] = ZERO_PR;
        rdy_d[ZERO_REG] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                map_q[i] <= PRW'(i);
            end
            rdy_q <= '1;
        end else begin
            map_q <= map_d;
            rdy_q <= rdy_d;
        end
    end

    map_ckpt_bank u_ckpt_bank (
        .clock         (clock),
        .reset         (reset),
        .take_en       (dispatch_en && ckpt_en),
        .take_map      (map_d),
        .take_rdy      (rdy_d),
        .cdb_valid     (cdb.valid),
        .cdb_tag       (cdb.T_idx),
        .rollback_en   (rollback_en),
        .rollback_ckpt (rollback_ckpt),
        .resolve_en    (resolve_en),
        .resolve_ckpt  (resolve_ckpt),
        .restore_map   (restore_map),
        .restore_rdy   (restore_rdy),
        .ckpt_tail     (ckpt_tail),
        .ckpt_avail    (ckpt_avail)
    );

    // A branch may only dispatch when a checkpoint slot is free.
    always_ff @(posedge clock) begin
        if (!reset && !rollback_en && dispatch_en && ckpt_en) begin
            assert (ckpt_avail) else $error("map_table: checkpoint requested with none available");
        end
    end

endmodule

// File: tb/tb_map_table.sv
// Self-checking bench for map_table: directed scenarios plus a randomized run
// against an array-based reference model of the rename table and checkpoints.
module tb_map_table;

    logic       clock;
    logic       reset;
    logic       dispatch_en;
    logic [4:0] src1_idx;
    logic [4:0] src2_idx;
    logic [4:0] dest_idx;
    logic [5:0] T_idx;
    logic       ckpt_en;
    logic       CDB_valid;
    logic [5:0] CDB_T_idx;
    logic       rollback_en;
    logic [1:0] rollback_ckpt;
    logic       resolve_en;
    logic [1:0] resolve_ckpt;
    logic [5:0] T1_idx;
    logic [5:0] T2_idx;
    logic       T1_ready;
    logic       T2_ready;
    logic [5:0] Told_idx;
    logic [1:0] ckpt_id;
    logic       ckpt_avail;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_map [32];
    bit m_rdy [32];
    int m_smap [4][32];
    bit m_srdy [4][32];
    bit m_val [4];
    int m_tail;

    map_table dut (
        .clock         (clock),
        .reset         (reset),
        .dispatch_en   (dispatch_en),
        .src1_idx      (src1_idx),
        .src2_idx      (src2_idx),
        .dest_idx      (dest_idx),
        .T_idx         (T_idx),
        .ckpt_en       (ckpt_en),
        .CDB_valid     (CDB_valid),
        .CDB_T_idx     (CDB_T_idx),
        .rollback_en   (rollback_en),
        .rollback_ckpt (rollback_ckpt),
        .resolve_en    (resolve_en),
        .resolve_ckpt  (resolve_ckpt),
        .T1_idx        (T1_idx),
        .T2_idx        (T2_idx),
        .T1_ready      (T1_ready),
        .T2_ready      (T2_ready),
        .Told_idx      (Told_idx),
        .ckpt_id       (ckpt_id),
        .ckpt_avail    (ckpt_avail)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int exp_tag(input int a);
        return m_map[a];
    endfunction

    function automatic bit exp_rdy(input int a);
        return m_rdy[a] || (CDB_valid && (int'(CDB_T_idx) == m_map[a]));
    endfunction

    function automatic int exp_told(input int d);
        return (d == 31) ? 31 : m_map[d];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_map[i] = i;
            m_rdy[i] = 1'b1;
        end
        for (int k = 0; k < 4; k++) m_val[k] = 1'b0;
        m_tail = 0;
    endtask

    task automatic idle();
        reset = 1'b0; dispatch_en = 1'b0; ckpt_en = 1'b0; CDB_valid = 1'b0;
        rollback_en = 1'b0; resolve_en = 1'b0; src1_idx = 5'd0; src2_idx = 5'd0;
        dest_idx = 5'd31; T_idx = 6'd0; CDB_T_idx = 6'd0; rollback_ckpt = 2'd0; resolve_ckpt = 2'd0;
    endtask

    // Advance model by one cycle from the current inputs, then clock the DUT.
    task automatic tick();
        bit squash [4];
        bit avail;
        int k;
        int old_tail;
        int rb;
        if (reset) begin
            model_reset();
        end else begin
            for (int s = 0; s < 4; s++)
                for (int i = 0; i < 32; i++)
                    if (CDB_valid && m_smap[s][i] == int'(CDB_T_idx)) m_srdy[s][i] = 1'b1;
            if (rollback_en) begin
                rb = int'(rollback_ckpt);
                for (int i = 0; i < 32; i++) begin
                    m_map[i] = m_smap[rb][i];
                    m_rdy[i] = m_srdy[rb][i];
                end
                for (int s = 0; s < 4; s++) squash[s] = 1'b0;
                old_tail = m_tail;
                k = rb;
                do begin
                    squash[k] = 1'b1;
                    k = (k + 1) % 4;
                end while (k != old_tail);
                for (int s = 0; s < 4; s++) if (squash[s]) m_val[s] = 1'b0;
                if (resolve_en && !squash[int'(resolve_ckpt)]) m_val[int'(resolve_ckpt)] = 1'b0;
                m_tail = rb;
            end else begin
                for (int i = 0; i < 32; i++)
                    if (CDB_valid && m_map[i] == int'(CDB_T_idx)) m_rdy[i] = 1'b1;
                if (dispatch_en && dest_idx != 5'd31) begin
                    m_map[int'(dest_idx)] = int'(T_idx);
                    m_rdy[int'(dest_idx)] = 1'b0;
                end
                avail = !m_val[m_tail];
                if (resolve_en) m_val[int'(resolve_ckpt)] = 1'b0;
                if (dispatch_en && ckpt_en && avail) begin
                    for (int i = 0; i < 32; i++) begin
                        m_smap[m_tail][i] = m_map[i];
                        m_srdy[m_tail][i] = m_rdy[i];
                    end
                    m_val[m_tail] = 1'b1;
                    m_tail = (m_tail + 1) % 4;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        idle();
        src1_idx = 5'd3; src2_idx = 5'd31; dest_idx = 5'd7;
        #1;
        n_vec++; if (T1_idx !== 6'd3) begin n_err++; $display("FAIL reset_t1 got=%0d exp=3", T1_idx); end
        n_vec++; if (T2_idx !== 6'd31) begin n_err++; $display("FAIL reset_t2 got=%0d exp=31", T2_idx); end
        n_vec++; if (T1_ready !== 1'b1 || T2_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b%b exp=11", T1_ready, T2_ready); end
        n_vec++; if (Told_idx !== 6'd7) begin n_err++; $display("FAIL reset_told got=%0d exp=7", Told_idx); end
        n_vec++; if (ckpt_avail !== 1'b1 || ckpt_id !== 2'd0) begin n_err++; $display("FAIL reset_ckpt got=%b/%0d exp=1/0", ckpt_avail, ckpt_id); end
    endtask

    task automatic test_rename();
        idle();
        dispatch_en = 1'b1; dest_idx = 5'd5; T_idx = 6'd40;
        tick();
        idle();
        src1_idx = 5'd5; dest_idx = 5'd5;
        #1;
        n_vec++; if (T1_idx !== 6'd40) begin n_err++; $display("FAIL rename_t1 got=%0d exp=40", T1_idx); end
        n_vec++; if (T1_ready !== 1'b0) begin n_err++; $display("FAIL rename_notready got=%b exp=0", T1_ready); end
        n_vec++; if (Told_idx !== 6'd40) begin n_err++; $display("FAIL rename_told got=%0d exp=40", Told_idx); end
        CDB_valid = 1'b1; CDB_T_idx = 6'd40;
        #1;
        n_vec++; if (T1_ready !== 1'b1) begin n_err++; $display("FAIL cdb_bypass got=%b exp=1", T1_ready); end
        tick();
        CDB_valid = 1'b0;
        #1;
        n_vec++; if (T1_ready !== 1'b1) begin n_err++; $display("FAIL cdb_sticky got=%b exp=1", T1_ready); end
    endtask

    task automatic test_same_src_dest();
        idle();
        dispatch_en = 1'b1; src1_idx = 5'd5; dest_idx = 5'd5; T_idx = 6'd41;
        #1;
        n_vec++; if (T1_idx !== 6'd40) begin n_err++; $display("FAIL samereg_t1 got=%0d exp=40", T1_idx); end
        n_vec++; if (Told_idx !== 6'd40) begin n_err++; $display("FAIL samereg_told got=%0d exp=40", Told_idx); end
        tick();
        idle();
        src1_idx = 5'd5;
        #1;
        n_vec++; if (T1_idx !== 6'd41 || T1_ready !== 1'b0) begin n_err++; $display("FAIL samereg_after got=%0d/%b exp=41/0", T1_idx, T1_ready); end
    endtask

    task automatic test_rollback();
        idle();
        dispatch_en = 1'b1; ckpt_en = 1'b1;
        #1;
        n_vec++; if (ckpt_id !== 2'd0) begin n_err++; $display("FAIL ckpt0_id got=%0d exp=0", ckpt_id); end
        tick();
        idle();
        dispatch_en = 1'b1; ckpt_en = 1'b1; dest_idx = 5'd5; T_idx = 6'd42;
        #1;
        n_vec++; if (ckpt_id !== 2'd1) begin n_err++; $display("FAIL ckpt1_id got=%0d exp=1", ckpt_id); end
        tick();
        idle();
        CDB_valid = 1'b1; CDB_T_idx = 6'd41;
        tick();
        idle();
        rollback_en = 1'b1; rollback_ckpt = 2'd0;
        tick();
        idle();
        src1_idx = 5'd5;
        #1;
        n_vec++; if (T1_idx !== 6'd41 || T1_ready !== 1'b1) begin n_err++; $display("FAIL rollback_map got=%0d/%b exp=41/1", T1_idx, T1_ready); end
        n_vec++; if (ckpt_id !== 2'd0 || ckpt_avail !== 1'b1) begin n_err++; $display("FAIL rollback_tail got=%0d/%b exp=0/1", ckpt_id, ckpt_avail); end
    endtask

    task automatic test_ckpt_full();
        for (int i = 0; i < 4; i++) begin
            idle();
            dispatch_en = 1'b1; ckpt_en = 1'b1;
            #1;
            n_vec++; if (ckpt_id !== 2'(i)) begin n_err++; $display("FAIL full_id%0d got=%0d exp=%0d", i, ckpt_id, i); end
            tick();
        end
        idle();
        #1;
        n_vec++; if (ckpt_avail !== 1'b0) begin n_err++; $display("FAIL full_avail got=%b exp=0", ckpt_avail); end
        ckpt_en = 1'b1;
        tick();
        idle();
        #1;
        n_vec++; if (ckpt_avail !== 1'b0 || ckpt_id !== 2'd0) begin n_err++; $display("FAIL full_ignore got=%b/%0d exp=0/0", ckpt_avail, ckpt_id); end
        resolve_en = 1'b1; resolve_ckpt = 2'd2;
        tick();
        idle();
        #1;
        n_vec++; if (ckpt_avail !== 1'b0) begin n_err++; $display("FAIL resolve2_avail got=%b exp=0", ckpt_avail); end
        resolve_en = 1'b1; resolve_ckpt = 2'd0;
        tick();
        idle();
        #1;
        n_vec++; if (ckpt_avail !== 1'b1 || ckpt_id !== 2'd0) begin n_err++; $display("FAIL resolve0 got=%b/%0d exp=1/0", ckpt_avail, ckpt_id); end
        resolve_en = 1'b1; resolve_ckpt = 2'd1;
        tick();
        resolve_ckpt = 2'd3;
        tick();
    endtask

    task automatic test_rollback_collision();
        idle();
        dispatch_en = 1'b1; dest_idx = 5'd7; T_idx = 6'd45;
        tick();
        idle();
        dispatch_en = 1'b1; ckpt_en = 1'b1;
        tick();
        idle();
        dispatch_en = 1'b1; dest_idx = 5'd7; T_idx = 6'd46;
        tick();
        idle();
        rollback_en = 1'b1; rollback_ckpt = 2'd0;
        dispatch_en = 1'b1; ckpt_en = 1'b1; dest_idx = 5'd8; T_idx = 6'd47;
        CDB_valid = 1'b1; CDB_T_idx = 6'd45;
        tick();
        idle();
        src1_idx = 5'd7; src2_idx = 5'd8; dest_idx = 5'd8;
        #1;
        n_vec++; if (T1_idx !== 6'd45 || T1_ready !== 1'b1) begin n_err++; $display("FAIL collide_cdb got=%0d/%b exp=45/1", T1_idx, T1_ready); end
        n_vec++; if (T2_idx !== 6'd8 || Told_idx !== 6'd8) begin n_err++; $display("FAIL collide_dispatch got=%0d/%0d exp=8/8", T2_idx, Told_idx); end
        n_vec++; if (ckpt_id !== 2'd0 || ckpt_avail !== 1'b1) begin n_err++; $display("FAIL collide_ckpt got=%0d/%b exp=0/1", ckpt_id, ckpt_avail); end
    endtask

    task automatic test_random();
        int cand[$];
        for (int c = 0; c < 1500; c++) begin
            idle();
            src1_idx = 5'($urandom_range(31, 0));
            src2_idx = 5'($urandom_range(31, 0));
            dest_idx = 5'($urandom_range(31, 0));
            T_idx = 6'($urandom_range(63, 32));
            dispatch_en = ($urandom_range(9, 0) < 7);
            ckpt_en = ($urandom_range(3, 0) == 0) && !m_val[m_tail];
            CDB_valid = ($urandom_range(1, 0) == 1);
            CDB_T_idx = ($urandom_range(1, 0) == 1) ? 6'(m_map[$urandom_range(31, 0)]) : 6'($urandom_range(63, 0));
            cand.delete();
            for (int k = 0; k < 4; k++) if (m_val[k]) cand.push_back(k);
            if (cand.size() > 0 && $urandom_range(19, 0) == 0) begin
                rollback_en = 1'b1;
                rollback_ckpt = 2'(cand[$urandom_range(cand.size() - 1, 0)]);
            end
            if (cand.size() > 0 && $urandom_range(5, 0) == 0) begin
                resolve_en = 1'b1;
                resolve_ckpt = 2'(cand[$urandom_range(cand.size() - 1, 0)]);
            end
            reset = ($urandom_range(299, 0) == 0);
            #1;
            n_vec++; if (T1_idx !== 6'(exp_tag(int'(src1_idx)))) begin n_err++; $display("FAIL rnd_t1 cyc=%0d got=%0d exp=%0d", c, T1_idx, exp_tag(int'(src1_idx))); end
            n_vec++; if (T2_idx !== 6'(exp_tag(int'(src2_idx)))) begin n_err++; $display("FAIL rnd_t2 cyc=%0d got=%0d exp=%0d", c, T2_idx, exp_tag(int'(src2_idx))); end
            n_vec++; if (T1_ready !== exp_rdy(int'(src1_idx))) begin n_err++; $display("FAIL rnd_t1r cyc=%0d got=%b exp=%b", c, T1_ready, exp_rdy(int'(src1_idx))); end
            n_vec++; if (T2_ready !== exp_rdy(int'(src2_idx))) begin n_err++; $display("FAIL rnd_t2r cyc=%0d got=%b exp=%b", c, T2_ready, exp_rdy(int'(src2_idx))); end
            n_vec++; if (Told_idx !== 6'(exp_told(int'(dest_idx)))) begin n_err++; $display("FAIL rnd_told cyc=%0d got=%0d exp=%0d", c, Told_idx, exp_told(int'(dest_idx))); end
            n_vec++; if (ckpt_id !== 2'(m_tail)) begin n_err++; $display("FAIL rnd_ckpt_id cyc=%0d got=%0d exp=%0d", c, ckpt_id, m_tail); end
            n_vec++; if (ckpt_avail !== !m_val[m_tail]) begin n_err++; $display("FAIL rnd_avail cyc=%0d got=%b exp=%b", c, ckpt_avail, !m_val[m_tail]); end
            tick();
        end
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clock);
        test_reset();
        test_rename();
        test_same_src_dest();
        test_rollback();
        test_ckpt_full();
        test_rollback_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
